// File: rtl/optical_sw_pkg.sv
// Shared constants, FSM encoding and a width helper for the optical switch driver.
package optical_sw_pkg;

    localparam logic P_BAR   = 1'b0;
    localparam logic P_CROSS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } sw_state_t;

    // Smallest r with 2**r >= value; constant-evaluable for widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/optical_sw_timer.sv
// Down-counter shared by the SETUP and SETTLE phases; parks at zero, never wraps.
module optical_sw_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] load_val,
    input  logic         load,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)                 cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (en && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/optical_switch_driver.sv
// Applies the controller's BAR/CROSS grant to the 2x2 switch drive pins with setup,
// strobe and settle timing. Optional completion counter: OPT_SW_CFG_CNT_EN.
module optical_switch_driver
    import optical_sw_pkg::*;
#(
    parameter logic P_BAR        = optical_sw_pkg::P_BAR,
    parameter logic P_CROSS      = optical_sw_pkg::P_CROSS,
    parameter int   P_SWITCHNUM  = 4,
    parameter int   P_SETUP_CYC  = 2,
    parameter int   P_SETTLE_CYC = 16,
    parameter int   P_CNTWIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [P_SWITCHNUM-1:0] i_switch_grant,
    input  logic                   i_grant_valid,
    output logic [P_SWITCHNUM-1:0] o_sw_ctrl,
    output logic                   o_sw_strobe,
    output logic                   o_busy,
    output logic                   o_config_end,
    output logic                   o_overrun
`ifdef OPT_SW_CFG_CNT_EN
   ,output logic [P_CNTWIDTH-1:0]  o_cfg_cnt
`endif
);

    localparam int TMAX = (P_SETUP_CYC > P_SETTLE_CYC) ? P_SETUP_CYC : P_SETTLE_CYC;
    localparam int TW   = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);
    localparam logic [TW-1:0] SETUP_LD  = TW'(P_SETUP_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(P_SETTLE_CYC - 1);

    sw_state_t state_q, state_d;
    logic          valid_q, rise, first_cfg, capture;
    logic          tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_val;

    assign rise = i_grant_valid & ~valid_q;

    optical_sw_timer #(.W(TW)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load_val (tmr_val),
        .load     (tmr_load),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = SETUP_LD;
        tmr_en   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    // Unchanged grant after the first job needs no optical move.
                    if (first_cfg || i_switch_grant != o_sw_ctrl) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            first_cfg    <= 1'b1;
            o_sw_ctrl    <= {P_SWITCHNUM{P_CROSS}};
            o_sw_strobe  <= 1'b0;
            o_busy       <= 1'b0;
            o_config_end <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            valid_q      <= i_grant_valid;
            o_sw_strobe  <= (state_d == ST_STROBE);
            o_busy       <= (state_d != ST_IDLE);
            o_config_end <= (state_d == ST_DONE);
            if (capture)               o_sw_ctrl <= i_switch_grant;
            if (state_q == ST_DONE)    first_cfg <= 1'b0;
            if (rise && state_q != ST_IDLE) o_overrun <= 1'b1;
        end
    end

`ifdef OPT_SW_CFG_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)                  o_cfg_cnt <= '0;
        else if (state_q == ST_DONE) o_cfg_cnt <= o_cfg_cnt + 1'b1;
    end
`else
`endif

endmodule

// File: tb/tb_optical_switch_driver.sv
// Directed and randomized checks of optical_switch_driver against a job-timeline model.
module tb_optical_switch_driver;

    localparam int N      = 4;
    localparam int SETUP  = 2;
    localparam int SETTLE = 16;
    localparam int CW     = 16;

    logic          clk = 1'b0;
    logic          rst, valid;
    logic [N-1:0]  grant, sw_ctrl;
    logic          strobe, busy, cend, ovr;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int n_end  = 0;

    // Model: a job is a timeline of length m_len cycles after capture.
    logic [N-1:0]  m_ctrl;
    logic          m_first, m_ovr, m_prev, m_full;
    int            m_job, m_len;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    optical_switch_driver #(
        .P_SWITCHNUM (N),
        .P_SETUP_CYC (SETUP),
        .P_SETTLE_CYC(SETTLE),
        .P_CNTWIDTH  (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_switch_grant (grant),
        .i_grant_valid  (valid),
        .o_sw_ctrl      (sw_ctrl),
        .o_sw_strobe    (strobe),
        .o_busy         (busy),
        .o_config_end   (cend),
        .o_overrun      (ovr)
`ifdef OPT_SW_CFG_CNT_EN
       ,.o_cfg_cnt      (cnt)
`endif
    );

`ifndef OPT_SW_CFG_CNT_EN
    assign cnt = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [N-1:0] g);
        logic rise;
        if (r) begin
            m_ctrl = {N{1'b1}}; m_first = 1'b1; m_ovr = 1'b0; m_prev = 1'b0;
            m_job = -1; m_len = 0; m_full = 1'b0; m_cnt = '0;
        end else begin
            rise = v && !m_prev;
            if (m_job >= 0) begin
                if (rise) m_ovr = 1'b1;
                if (m_job == m_len) begin
                    m_job = -1; m_first = 1'b0; m_cnt = m_cnt + 1'b1;
                end else begin
                    m_job++;
                end
            end else if (rise) begin
                m_full = m_first || (g != m_ctrl);
                m_ctrl = g;
                m_len  = m_full ? SETUP + SETTLE + 1 : 0;
                m_job  = 0;
            end
            m_prev = v;
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [N-1:0] g);
        rst = r; valid = v; grant = g;
        @(posedge clk);
        model_edge(r, v, g);
        #1;
        chk("sw_ctrl",    32'(sw_ctrl), 32'(m_ctrl));
        chk("strobe",     32'(strobe),  32'(m_job == SETUP && m_full));
        chk("busy",       32'(busy),    32'(m_job >= 0));
        chk("config_end", 32'(cend),    32'(m_job >= 0 && m_job == m_len));
        chk("overrun",    32'(ovr),     32'(m_ovr));
`ifdef OPT_SW_CFG_CNT_EN
        chk("cfg_cnt",    32'(cnt),     32'(m_cnt));
`endif
        if (cend) n_end++;
    endtask

    initial begin
        logic          v;
        logic [N-1:0]  g;
        m_ctrl = '0; m_first = 1'b1; m_ovr = 1'b0; m_prev = 1'b0;
        m_job = -1; m_len = 0; m_full = 1'b0; m_cnt = '0;
        rst = 1'b1; valid = 1'b0; grant = '0;

        cyc(1, 0, 4'h0);
        cyc(1, 0, 4'h0);
        chk("reset_ctrl", 32'(sw_ctrl), 32'hF);

        // Full path, then valid held: exactly one completion.
        n_end = 0;
        repeat (40) cyc(0, 1, 4'b0101);
        chk("held_one_end", 32'(n_end), 32'd1);
`ifdef OPT_SW_CFG_CNT_EN
        chk("cnt_after_1", 32'(cnt), 32'd1);
`endif

        // Same grant again: skip path.
        repeat (2) cyc(0, 0, 4'b0101);
        n_end = 0;
        cyc(0, 1, 4'b0101);
        chk("skip_end_next", 32'(cend), 32'd1);
        repeat (5) cyc(0, 1, 4'b1010);
        chk("skip_ctrl_kept", 32'(sw_ctrl), 32'b0101);
`ifdef OPT_SW_CFG_CNT_EN
        chk("cnt_after_2", 32'(cnt), 32'd2);
`endif
        cyc(0, 0, 4'b0000);

        // First request after reset equals the reset value: still full path.
        cyc(1, 0, 4'hF);
        cyc(0, 1, 4'hF);
        cyc(0, 1, 4'hF);
        cyc(0, 1, 4'hF);
        chk("first_cfg_strobe", 32'(strobe), 32'd1);
        repeat (22) cyc(0, 1, 4'hF);
        cyc(0, 0, 4'hF);

        // Second rising edge mid-job: dropped, overrun latches.
        cyc(0, 1, 4'b0011);
        for (int k = 1; k < 30; k++) cyc(0, (k == 7) ? 1'b0 : 1'b1, 4'b1100);
        chk("overrun_sticky", 32'(ovr), 32'd1);
        chk("overrun_ctrl", 32'(sw_ctrl), 32'b0011);
        cyc(0, 0, 4'b0000);

        // Reset in SETTLE aborts the job.
        cyc(1, 0, 4'b0000);
        cyc(0, 1, 4'b1010);
        repeat (9) cyc(0, 1, 4'b1010);
        n_end = 0;
        cyc(1, 0, 4'b1010);
        chk("abort_ctrl", 32'(sw_ctrl), 32'hF);
        repeat (20) cyc(0, 0, 4'b1010);
        chk("abort_no_end", 32'(n_end), 32'd0);

        // Randomized traffic.
        v = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) v = ~v;
            g = ($urandom_range(0, 1) == 0) ? m_ctrl : N'($urandom);
            cyc(($urandom_range(0, 299) == 0), v, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
